// File: rtl/mode_ctrl_pkg.sv
// Shared encodings and song arithmetic for the mode controller.
// The FSM state and song values are driven straight from these constants.
package mode_ctrl_pkg;

  localparam int STATE_BITS = 3;
  localparam int SONG_BITS  = 2;

  localparam logic [STATE_BITS-1:0] MENU_MODE = 3'd0;
  localparam logic [STATE_BITS-1:0] FREE_MODE = 3'd1;
  localparam logic [STATE_BITS-1:0] AUTO_MODE = 3'd2;
  localparam logic [STATE_BITS-1:0] STDY_MODE = 3'd3;
  localparam logic [STATE_BITS-1:0] PLAY_MODE = 3'd4;
  localparam logic [STATE_BITS-1:0] SET_MODE  = 3'd5;

  localparam logic [SONG_BITS-1:0] LITTLE_STAR    = 2'd0;
  localparam logic [SONG_BITS-1:0] TWO_TIGERS     = 2'd1;
  localparam logic [SONG_BITS-1:0] HAPPY_BIRTHDAY = 2'd2;

  localparam int unsigned SONG_COUNT = 32'd3;

  // Explicit modulo-3 so the unused encoding 3 can never be reached.
  function automatic logic [SONG_BITS-1:0] song_inc(input logic [SONG_BITS-1:0] s);
    int unsigned v;
    v = (32'(s) + 32'd1) % SONG_COUNT;
    return SONG_BITS'(v);
  endfunction

  function automatic logic [SONG_BITS-1:0] song_dec(input logic [SONG_BITS-1:0] s);
    int unsigned v;
    v = (32'(s) + SONG_COUNT - 32'd1) % SONG_COUNT;
    return SONG_BITS'(v);
  endfunction

  function automatic logic is_song_state(input logic [STATE_BITS-1:0] st);
    return (st == AUTO_MODE) || (st == STDY_MODE) || (st == PLAY_MODE);
  endfunction

  function automatic logic is_target_state(input logic [STATE_BITS-1:0] st);
    return (st != MENU_MODE) && (st <= SET_MODE);
  endfunction

endpackage

// File: rtl/mode_ctrl_btn_debounce.sv
// Two-flop synchronizer plus press debouncer: one pulse per press, and the
// button must be seen low for a full debounce window before it can fire again.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ARMED  = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [1:0]       sync_q, sync_d;
  logic [0:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level;

  assign level       = sync_q[1];
  assign press_pulse = pulse_q;

  always_comb begin
    sync_d  = {sync_q[0], btn_in};
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (mode_q == ARMED) begin
      if (!level) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        pulse_d = 1'b1;
        mode_d  = LOCKED;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // LOCKED counts consecutive low cycles before re-arming.
      if (level) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        mode_d = ARMED;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Reset lands in LOCKED so a button held across reset cannot fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      mode_q  <= LOCKED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// Mode/song controller: debounced buttons drive the mode FSM and song index,
// and play_start restarts the player on entry to a playing mode or song change.
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_confirm,
  input  logic                  btn_back,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic [STATE_BITS-1:0] sw_mode,
  input  logic                  song_done,
  output logic [STATE_BITS-1:0] state,
  output logic [SONG_BITS-1:0]  song,
  output logic                  play_start
);

  logic confirm_p, back_p, up_p, down_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
    .clk(clk), .rst(rst), .btn_in(btn_confirm), .press_pulse(confirm_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clk(clk), .rst(rst), .btn_in(btn_back), .press_pulse(back_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_in(btn_up), .press_pulse(up_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_in(btn_down), .press_pulse(down_p)
  );

  logic [STATE_BITS-1:0] state_q, state_d;
  logic [SONG_BITS-1:0]  song_q, song_d;
  logic                  play_start_q, play_start_d;

  assign state      = state_q;
  assign song       = song_q;
  assign play_start = play_start_q;

  // Priority back > confirm > up > down > song_done; an event that does not
  // apply in the current state does not mask the ones below it.
  always_comb begin
    state_d      = state_q;
    song_d       = song_q;
    play_start_d = 1'b0;
    if (back_p && (state_q != MENU_MODE)) begin
      state_d = MENU_MODE;
    end else if (confirm_p && (state_q == MENU_MODE) && is_target_state(sw_mode)) begin
      state_d      = sw_mode;
      play_start_d = is_song_state(sw_mode);
    end else if (up_p && is_song_state(state_q)) begin
      song_d       = song_inc(song_q);
      play_start_d = 1'b1;
    end else if (down_p && is_song_state(state_q)) begin
      song_d       = song_dec(song_q);
      play_start_d = 1'b1;
    end else if (song_done && (state_q == AUTO_MODE)) begin
      song_d       = song_inc(song_q);
      play_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MENU_MODE;
      song_q       <= LITTLE_STAR;
      play_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      song_q       <= song_d;
      play_start_q <= play_start_d;
    end
  end

endmodule

// File: tb/tb_mode_ctrl.sv
// Scoreboard bench for mode_ctrl: a behavioural model queues the expected
// {state, song, play_start} for every press; a monitor pops on each output event.
module tb_mode_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = DB + 6;
  localparam int SB   = 3;
  localparam int GB   = 2;
  localparam int W    = SB + GB + 1;

  localparam int S_MENU = 0, S_FREE = 1, S_AUTO = 2, S_STDY = 3, S_PLAY = 4, S_SET = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_confirm = 1'b0, btn_back = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [SB-1:0] sw_mode = '0;
  logic          song_done = 1'b0;
  logic [SB-1:0] state;
  logic [GB-1:0] song;
  logic          play_start;

  mode_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .btn_confirm(btn_confirm), .btn_back(btn_back), .btn_up(btn_up), .btn_down(btn_down),
    .sw_mode(sw_mode), .song_done(song_done),
    .state(state), .song(song), .play_start(play_start)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int m_state  = S_MENU;
  int m_song   = 0;
  bit mon_en   = 1'b0;

  function automatic bit in_song_mode(int st);
    return (st == S_AUTO) || (st == S_STDY) || (st == S_PLAY);
  endfunction

  function automatic void expect_out(int st, int sg, bit ps);
    exp_q.push_back({SB'(st), GB'(sg), ps});
  endfunction

  // Reference model: applies one cycle's worth of events to the abstract mode/song.
  task automatic model_events(bit c, bit b, bit u, bit d, bit sd);
    int sw;
    sw = int'(sw_mode);
    if (b && m_state != S_MENU) begin
      m_state = S_MENU;
      expect_out(m_state, m_song, 1'b0);
    end else if (c && m_state == S_MENU && sw >= S_FREE && sw <= S_SET) begin
      m_state = sw;
      expect_out(m_state, m_song, in_song_mode(sw));
    end else if (u && in_song_mode(m_state)) begin
      m_song = (m_song + 1) % 3;
      expect_out(m_state, m_song, 1'b1);
    end else if (d && in_song_mode(m_state)) begin
      m_song = (m_song + 2) % 3;
      expect_out(m_state, m_song, 1'b1);
    end else if (sd && m_state == S_AUTO) begin
      m_song = (m_song + 1) % 3;
      expect_out(m_state, m_song, 1'b1);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] prev, cur, exp;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {state, song, play_start};
      if (mon_en && ((cur[W-1:1] != prev[W-1:1]) || play_start)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got state=%0d song=%0d play_start=%0b, required no change",
                   state, song, play_start);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            failures++;
            $display("FAIL output_event got state=%0d song=%0d play_start=%0b, required state=%0d song=%0d play_start=%0b",
                     state, song, play_start, exp[W-1:GB+1], exp[GB:1], exp[0]);
          end
        end
      end
      prev = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(logic [3:0] m);
    {btn_confirm, btn_back, btn_up, btn_down} = m;
  endtask

  task automatic check_val(string name, int got, int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      cycles(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got pending=%0d required pending=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // mask = {confirm, back, up, down}
  task automatic press(logic [3:0] m, bit bounce);
    if (bounce) begin
      drive(m); cycles(1); drive(4'b0); cycles(1);
      drive(m); cycles(1); drive(4'b0); cycles(1);
    end
    model_events(m[3], m[2], m[1], m[0], 1'b0);
    drive(m);
    cycles(HOLD);
    drive(4'b0);
    cycles(HOLD);
    drain("press");
  endtask

  task automatic pulse_song_done();
    song_done = 1'b1;
    model_events(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycles(1);
    song_done = 1'b0;
    cycles(2);
    drain("song_done");
  endtask

  task automatic apply_reset(int len);
    mon_en = 1'b0;
    rst = 1'b1;
    cycles(len);
    rst = 1'b0;
    exp_q.delete();
    m_state = S_MENU;
    m_song  = 0;
    check_val("reset_state", int'(state), S_MENU);
    check_val("reset_song", int'(song), 0);
    check_val("reset_play_start", int'(play_start), 0);
    mon_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    sw_mode = SB'(S_AUTO);
    drive(4'b1000);
    apply_reset(2);
    cycles(12);                     // confirm still held: nothing may happen
    drive(4'b0);
    cycles(HOLD);

    press(4'b1000, 1'b1);           // bounce then hold -> auto_mode
    pulse_song_done();
    pulse_song_done();
    pulse_song_done();
    pulse_song_done();              // song 1
    press(4'b0110, 1'b0);           // back + up together -> menu, song kept

    sw_mode = SB'(S_PLAY);
    press(4'b1000, 1'b0);
    press(4'b0010, 1'b0);           // song 2
    press(4'b0010, 1'b0);           // wrap to 0
    press(4'b0001, 1'b0);           // wrap back to 2
    press(4'b0100, 1'b0);

    sw_mode = SB'(S_STDY);
    press(4'b1000, 1'b0);
    pulse_song_done();              // ignored outside auto_mode
    press(4'b0100, 1'b0);

    sw_mode = 3'd7;
    press(4'b1000, 1'b0);           // invalid target, stays in menu
    sw_mode = SB'(S_SET);
    press(4'b1000, 1'b0);
    press(4'b0010, 1'b0);           // up ignored in set
    press(4'b0100, 1'b0);

    // Reset in the middle of a debounce, button held across release.
    sw_mode = SB'(S_AUTO);
    drive(4'b1000);
    cycles(3);
    apply_reset(2);
    cycles(12);
    drive(4'b0);
    cycles(HOLD);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: sw_mode = SB'($urandom_range(0, 7));
        2, 3: press(4'b1000, 1'($urandom_range(0, 1)));
        4:    press(4'b0100, 1'($urandom_range(0, 1)));
        5, 6: press(4'b0010, 1'($urandom_range(0, 1)));
        7:    press(4'b0001, 1'($urandom_range(0, 1)));
        8:    pulse_song_done();
        default: press(4'($urandom_range(1, 15)), 1'b0);
      endcase
    end

    cycles(4);
    check_val("final_state", int'(state), m_state);
    check_val("final_song", int'(song), m_song);
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_ctrl.md
MODE_CTRL -- requirements
Module: mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2000000, is the number of consecutive stable-high clk cycles required to accept a button press (20 ms at 100 MHz).
REQ-002 clk  input  1  system clock, 100 MHz; one clock domain; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn_confirm  input  1  raw confirm button, asynchronous to clk, active-high.
REQ-005 btn_back  input  1  raw back button, active-high.
REQ-006 btn_up  input  1  raw next-song button, active-high.
REQ-007 btn_down  input  1  raw previous-song button, active-high.
REQ-008 sw_mode  input  3  mode selector switches; sampled only in menu_mode.
REQ-009 song_done  input  1  one-cycle pulse from the note player at the end of a song.
REQ-010 state  output  STATE_BITS  current mode; consumed by the display menu stage.
REQ-011 song  output  SONG_BITS  current song index; consumed by the display menu stage and the player.
REQ-012 play_start  output  1  one-cycle pulse that restarts the player at note 0.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer and then a debouncer that emits one press pulse after DEBOUNCE_CYCLES consecutive synchronized-high cycles, with exactly one pulse per press.
REQ-014 A new pulse for a button SHALL require that button to be low for DEBOUNCE_CYCLES consecutive cycles first; a held button SHALL NOT repeat.
REQ-015 The FSM SHALL have the states menu_mode, free_mode, auto_mode, stdy_mode, play_mode and set, and state SHALL equal the FSM register directly.
REQ-016 menu_mode + confirm SHALL move to the state whose encoding equals sw_mode on the next cycle; sw_mode = menu_mode, 6 or 7 SHALL leave the FSM in menu_mode.
REQ-017 In any state other than menu_mode, back SHALL return the FSM to menu_mode on the next cycle; song SHALL be retained.
REQ-018 In auto_mode, stdy_mode or play_mode, up SHALL set song to song+1 and down SHALL set song to song-1, wrapping happy_birthday to little_star and little_star to happy_birthday.
REQ-019 In auto_mode only, song_done SHALL advance song with the same wrap as up; in every other state song_done SHALL be ignored.
REQ-020 In free_mode and set, up, down and confirm SHALL be ignored; in menu_mode, up, down and back SHALL be ignored.
REQ-021 Priority for same-cycle events SHALL be back > confirm > up > down > song_done; only the highest-priority event takes effect and the rest are dropped.
REQ-022 play_start SHALL pulse for exactly one cycle, coincident with the new state or song value, on entry to auto_mode, stdy_mode or play_mode and on every song change; it SHALL be 0 at all other times.
REQ-023 Latency from a debounced press pulse to the updated state/song SHALL be 1 clk cycle.
REQ-024 song SHALL never hold the unused encoding 3; song arithmetic SHALL be done modulo 3 explicitly, not by natural 2-bit wrap.

Reset
REQ-025 While rst is high on a rising edge: state = menu_mode, song = little_star, play_start = 0, and all synchronizers, debounce counters and pulse flags are cleared.
REQ-026 Reset asserted mid-debounce or mid-song SHALL discard the pending press or song; a button held through reset deassertion SHALL NOT produce a pulse until it is released and pressed again.

Structure
REQ-027 Constants.vh SHALL hold STATE_BITS = 3 with menu_mode = 0, free_mode = 1, auto_mode = 2, stdy_mode = 3, play_mode = 4, set = 5.
REQ-028 Constants.vh SHALL also hold SONG_BITS = 2 with little_star = 0, two_tigers = 1, happy_birthday = 2; no literal encodings SHALL appear in the RTL.
REQ-029 Synchronization and debounce SHALL be implemented once in the sub-module btn_debounce (clk, rst, btn_in, press_pulse), instantiated four times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Scenario: rst high 2 cycles, then released -> state = 0, song = 0, play_start = 0; btn_confirm held through reset produces no transition.
REQ-031 Scenario: btn_confirm bounces 1-0-1-0, then holds high 10 cycles, with sw_mode = 2 -> exactly one transition to state = 2 and one play_start pulse.
REQ-032 Scenario: in play_mode with song = 2, press btn_up -> song = 0 and play_start pulses; press btn_down -> song = 2.
REQ-033 Scenario: in auto_mode, three song_done pulses -> song sequence 1, 2, 0; in stdy_mode, a song_done pulse leaves song unchanged.
REQ-034 Scenario: btn_back and btn_up pulses land in the same cycle while in auto_mode with song = 1 -> state = 0, song = 1, no play_start.
REQ-035 Scenario: in menu_mode with sw_mode = 7, press confirm -> state stays 0; then set sw_mode = 5 and press confirm -> state = 5, and up has no effect in set.
